// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD data loader.
// Word/row geometry, loader state encoding and slot helper.
package sgd_pkg;

    localparam int LENGTH       = 16;
    localparam int MAX_FEATURES = 15;
    localparam int ADDR_WIDTH   = 12;
    localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int DEPTH_DEF    = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } ld_state_t;

    // MSB of word slot k; slot 0 (y or W0) is the top of the row
    function automatic int slot_msb(input int k);
        return DATA_WIDTH - 1 - LENGTH * k;
    endfunction

endpackage

// File: rtl/sgd_row_ram.sv
// Row RAM: DEPTH x DATA_WIDTH, synchronous write, asynchronous read, no reset.
// Ports: CLK, i_we/i_waddr/i_wdata write port, i_raddr -> o_rdata (0 if out of range).
module sgd_row_ram
    import sgd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  i_we,
    input  logic [IW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_raddr < ADDR_WIDTH'(DEPTH)) begin
            o_rdata = r_mem[i_raddr[IW-1:0]];
        end
    end

endmodule

// File: rtl/sgd_data_loader.sv
// Streams 16-bit words into packed rows of the SGD row RAM and reports load status.
// Ports: CLK/RST_N, start_load+cfg_feat, s_* stream, loaded/err/data_points, rd_addr->rd_data.
module sgd_data_loader
    import sgd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start_load,
    input  logic [3:0]            cfg_feat,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [LENGTH-1:0]     s_data,
    input  logic                  s_last,
    output logic                  loaded,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] data_points,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int IW = $clog2(DEPTH);

    ld_state_t             r_state;
    logic                  r_ready;
    logic                  r_loaded;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_points;
    logic [3:0]            r_feat;
    logic [3:0]            r_word_cnt;
    logic [ADDR_WIDTH-1:0] r_row_cnt;
    logic                  r_last_row;
    logic [DATA_WIDTH-1:0] r_row;

    logic                  w_acc;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_points;

    assign w_acc = s_valid && r_ready;
    assign w_we  = (r_state == ST_WRITE);

    // committed samples exclude the weight row
    assign w_points = (r_row_cnt == '0) ? '0 : r_row_cnt - 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b0;
            r_loaded   <= 1'b0;
            r_err      <= 1'b0;
            r_points   <= '0;
            r_feat     <= '0;
            r_word_cnt <= '0;
            r_row_cnt  <= '0;
            r_last_row <= 1'b0;
            r_row      <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_load) begin
                        r_loaded   <= 1'b0;
                        r_err      <= 1'b0;
                        r_word_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_last_row <= 1'b0;
                        r_row      <= '0;
                        if (cfg_feat == '0) begin
                            r_err    <= 1'b1;
                            r_loaded <= 1'b1;
                            r_points <= '0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_feat  <= cfg_feat;
                            r_ready <= 1'b1;
                            r_state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (w_acc) begin
                        for (int k = 0; k <= MAX_FEATURES; k++) begin
                            if (r_word_cnt == 4'(k)) begin
                                r_row[slot_msb(k) -: LENGTH] <= s_data;
                            end
                        end
                        if (r_word_cnt == r_feat) begin
                            r_word_cnt <= '0;
                            r_last_row <= s_last;
                            r_ready    <= 1'b0;
                            r_state    <= ST_WRITE;
                        end else if (s_last) begin
                            // short row: never written to RAM
                            r_err    <= 1'b1;
                            r_loaded <= 1'b1;
                            r_points <= w_points;
                            r_ready  <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_row     <= '0;
                    r_row_cnt <= r_row_cnt + 1'b1;
                    if (r_last_row) begin
                        r_loaded <= 1'b1;
                        r_points <= r_row_cnt;
                        r_state  <= ST_DONE;
                    end else if (r_row_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_err   <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_RECV;
                    end
                end
                ST_DRAIN: begin
                    if (w_acc && s_last) begin
                        r_loaded <= 1'b1;
                        r_points <= w_points;
                        r_ready  <= 1'b0;
                        r_state  <= ST_DONE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign loaded      = r_loaded;
    assign err         = r_err;
    assign data_points = r_points;

    sgd_row_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (r_row_cnt[IW-1:0]),
        .i_wdata (r_row),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

endmodule

// File: tb/tb_sgd_data_loader.sv
// Self-checking bench for sgd_data_loader (DEPTH=4 instance).
// Queue-level reference model checked every cycle plus literal row checks.
module tb_sgd_data_loader;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_load = 1'b0;
    logic [3:0]   cfg_feat = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [15:0]  s_data = '0;
    logic         s_last = 1'b0;
    logic         loaded;
    logic         err;
    logic [11:0]  data_points;
    logic [11:0]  rd_addr = '0;
    logic [255:0] rd_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sgd_data_loader #(
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .start_load  (start_load),
        .cfg_feat    (cfg_feat),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .loaded      (loaded),
        .err         (err),
        .data_points (data_points),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_active = 0;
    bit           m_commit = 0;
    bit           m_end    = 0;
    bit           m_drain  = 0;
    bit           m_loaded = 0;
    bit           m_err    = 0;
    int           m_rows   = 0;
    int           m_points = 0;
    int           m_f      = 0;
    logic [15:0]  rowq[$];
    logic [255:0] mem_m [DEPTH];
    bit           m_valid [DEPTH];

    function automatic bit m_ready();
        return m_active && !m_commit;
    endfunction

    task automatic m_finish();
        m_active = 0;
        m_drain  = 0;
        m_loaded = 1;
        m_points = (m_rows > 0) ? m_rows - 1 : 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_commit = 0; m_end = 0;
            m_drain = 0; m_loaded = 0; m_err = 0;
            m_rows = 0; m_points = 0;
            rowq.delete();
        end else if (m_commit) begin
            logic [255:0] p;
            p = '0;
            foreach (rowq[k])
                p |= {240'b0, rowq[k]} << (16 * (15 - k));
            mem_m[m_rows] = p;
            m_valid[m_rows] = 1;
            m_rows++;
            rowq.delete();
            m_commit = 0;
            if (m_end) m_finish();
            else if (m_rows == DEPTH) begin
                m_err = 1;
                m_drain = 1;
            end
        end else if (m_active) begin
            if (s_valid) begin
                if (m_drain) begin
                    if (s_last) m_finish();
                end else begin
                    rowq.push_back(s_data);
                    if (rowq.size() == m_f + 1) begin
                        m_commit = 1;
                        m_end = s_last;
                    end else if (s_last) begin
                        m_err = 1;
                        m_finish();
                    end
                end
            end
        end else if (start_load) begin
            m_loaded = 0; m_err = 0; m_rows = 0;
            m_drain = 0;
            rowq.delete();
            if (cfg_feat == 0) begin
                m_err = 1;
                m_finish();
            end else begin
                m_f = int'(cfg_feat);
                m_active = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("s_ready", s_ready, m_ready());
        chk("loaded", loaded, m_loaded);
        chk("err", err, m_err);
        chk("data_points", data_points, 256'(m_points));
        if (rd_addr >= 12'(DEPTH))
            chk("rd_oor", rd_data, '0);
        else if (m_valid[rd_addr[1:0]])
            chk("rd_data", rd_data, mem_m[rd_addr[1:0]]);
    end

    // ---------------- read address sweep ----------------
    bit          peek_en = 0;
    logic [11:0] peek_addr = '0;
    int          sweep = 0;

    always @(posedge clk) begin
        #1;
        sweep = (sweep + 1) % 5;
        if (peek_en) rd_addr = peek_addr;
        else if (sweep == 4) rd_addr = 12'd200;
        else rd_addr = 12'(sweep);
    end

    task automatic peek(input logic [11:0] a, output logic [255:0] d);
        peek_en = 1;
        peek_addr = a;
        @(posedge clk);
        #2;
        @(negedge clk);
        d = rd_data;
        peek_en = 0;
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] c, input logic sv);
        start_load = 1;
        cfg_feat = c;
        s_valid = sv;
        s_data = 16'hDEAD;
        step();
        start_load = 0;
        s_valid = 0;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int  t;
        bit  rdy;
        t = 0;
        s_valid = 1;
        s_data = d;
        s_last = l;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            step();
            if (rdy) break;
            t++;
            if (t > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic wait_loaded(input string nm);
        int t;
        t = 0;
        while (loaded !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(nm, loaded, 1);
    endtask

    task automatic load(input logic [3:0] c, input logic [15:0] w[$],
                        input int gap);
        start(c, 1'b1);
        foreach (w[i]) begin
            if (gap > 0) begin
                int n;
                n = $urandom_range(0, gap);
                repeat (n) step();
            end
            send(w[i], i == w.size() - 1);
        end
    endtask

    logic [15:0]  q[$];
    logic [255:0] d;

    task automatic check_s1(input string tag);
        peek(12'd0, d);
        chk({tag, "_row0"}, d, {48'h0001_0002_0003, 208'b0});
        peek(12'd1, d);
        chk({tag, "_row1"}, d, {48'h000A_0001_0001, 208'b0});
        peek(12'd2, d);
        chk({tag, "_row2"}, d, {48'h0014_0002_0002, 208'b0});
        chk({tag, "_dp"}, data_points, 2);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_err", err, 0);
        chk("rst_dp", data_points, 0);
        step();
        rst_n = 1;
        step();

        // basic load; s_valid with start_load is not accepted
        q = '{16'd1, 16'd2, 16'd3, 16'd10, 16'd1, 16'd1,
              16'd20, 16'd2, 16'd2};
        load(4'd2, q, 0);
        wait_loaded("s1_loaded");
        check_s1("s1");

        // zero padding and out-of-range read
        q = '{16'd3, 16'd4, 16'd5, 16'd7};
        load(4'd1, q, 0);
        wait_loaded("s2_loaded");
        peek(12'd1, d);
        chk("s2_row1_hi", d[255:224], 32'h0005_0007);
        chk("s2_row1_pad", d[223:0], '0);
        peek(12'd200, d);
        chk("s2_oor", d, '0);

        // short row keeps stale row 2
        q = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd9, 16'd8,
              16'd7, 16'd6, 16'd5, 16'd5};
        load(4'd3, q, 0);
        wait_loaded("s3_loaded");
        chk("s3_err", err, 1);
        chk("s3_dp", data_points, 1);
        peek(12'd2, d);
        chk("s3_row2", d, {48'h0014_0002_0002, 208'b0});

        // zero feature count
        start(4'd0, 1'b0);
        @(negedge clk);
        chk("cfg0_err", err, 1);
        chk("cfg0_loaded", loaded, 1);
        step();

        // oversize: 6 rows into 4
        q.delete();
        for (int i = 0; i < 6; i++) begin
            q.push_back(16'(i + 1));
            q.push_back(16'(i + 33));
        end
        load(4'd1, q, 0);
        wait_loaded("s4_loaded");
        chk("s4_err", err, 1);
        chk("s4_dp", data_points, 3);
        peek(12'd3, d);
        chk("s4_row3", d, {32'h0004_0024, 224'b0});

        // backpressure gaps
        q = '{16'd1, 16'd2, 16'd3, 16'd10, 16'd1, 16'd1,
              16'd20, 16'd2, 16'd2};
        load(4'd2, q, 3);
        wait_loaded("s5_loaded");
        check_s1("s5");

        // reset during row 1
        start(4'd2, 1'b0);
        send(16'd1, 0);
        send(16'd2, 0);
        send(16'd3, 0);
        send(16'd10, 0);
        rst_n = 0;
        @(negedge clk);
        chk("s6_ready", s_ready, 0);
        chk("s6_loaded", loaded, 0);
        step();
        step();
        rst_n = 1;
        step();
        peek(12'd0, d);
        chk("s6_row0", d, {48'h0001_0002_0003, 208'b0});
        load(4'd2, q, 0);
        wait_loaded("s6_loaded2");
        check_s1("s6");

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
